// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with busy scoreboard.
// Two combinational reads, ALU and late-return write ports.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic              rd_busy1,
  output logic              rd_busy2,
  input  logic              wr_en_a,
  input  logic [ADDR_W-1:0] wr_addr_a,
  input  logic [DATA_W-1:0] wr_data_a,
  input  logic              wr_en_b,
  input  logic [ADDR_W-1:0] wr_addr_b,
  input  logic [DATA_W-1:0] wr_data_b,
  input  logic              busy_set,
  input  logic [ADDR_W-1:0] busy_addr,
  output logic              busy_any
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_nxt;
  logic              we_a;
  logic              we_b;
  logic              set_q;

  // Address 0 is a sink when the zero register is enabled.
  always_comb begin
    we_a  = wr_en_a;
    we_b  = wr_en_b;
    set_q = busy_set;
    if (ZERO_REG != 0) begin
      if (wr_addr_a == '0) we_a = 1'b0;
      if (wr_addr_b == '0) we_b = 1'b0;
      if (busy_addr == '0) set_q = 1'b0;
    end
  end

  // Register array update; port B overrides port A on collision.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (we_b && wr_addr_b == ADDR_W'(i)) begin
          mem[i] <= wr_data_b;
        end else if (we_a && wr_addr_a == ADDR_W'(i)) begin
          mem[i] <= wr_data_a;
        end
      end
    end
  end

  // Scoreboard next state: clear by B first, a new producer wins.
  always_comb begin
    busy_nxt = busy;
    if (wr_en_b) busy_nxt[wr_addr_b] = 1'b0;
    if (set_q)   busy_nxt[busy_addr] = 1'b1;
  end

  // Scoreboard register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

  // Busy summary reflects stored state only.
  always_comb begin
    busy_any = |busy;
  end

  // One read port: {busy, data} after bypass and zero rules.
  function automatic logic [DATA_W:0] rd_port(
    input logic [ADDR_W-1:0] a
  );
    logic [DATA_W-1:0] d;
    logic              b;
    d = mem[a];
    b = busy[a];
    if (BYPASS != 0 && reset) begin
      if (wr_en_b && wr_addr_b == a) begin
        d = wr_data_b;
        b = 1'b0;
      end else if (wr_en_a && wr_addr_a == a) begin
        d = wr_data_a;
      end
    end
    if (ZERO_REG != 0 && a == '0) begin
      d = '0;
      b = 1'b0;
    end
    return {b, d};
  endfunction

  // Read port 1.
  always_comb begin
    {rd_busy1, rd_data1} = rd_port(rd_addr1);
  end

  // Read port 2.
  always_comb begin
    {rd_busy2, rd_data2} = rd_port(rd_addr2);
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed table, random vs. model,
// and asynchronous reset sequences for regfile_mp.
module tb_regfile_mp;

  logic        clock;
  logic        reset;
  logic [4:0]  rd_addr1, rd_addr2;
  logic [31:0] rd_data1, rd_data2;
  logic        rd_busy1, rd_busy2;
  logic        wr_en_a, wr_en_b;
  logic [4:0]  wr_addr_a, wr_addr_b;
  logic [31:0] wr_data_a, wr_data_b;
  logic        busy_set;
  logic [4:0]  busy_addr;
  logic        busy_any;

  int vectors = 0;
  int errors  = 0;

  logic [31:0] m_mem  [32];
  logic        m_busy [32];

  regfile_mp dut (
    .clock(clock), .reset(reset),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(rd_data1), .rd_data2(rd_data2),
    .rd_busy1(rd_busy1), .rd_busy2(rd_busy2),
    .wr_en_a(wr_en_a), .wr_addr_a(wr_addr_a),
    .wr_data_a(wr_data_a),
    .wr_en_b(wr_en_b), .wr_addr_b(wr_addr_b),
    .wr_data_b(wr_data_b),
    .busy_set(busy_set), .busy_addr(busy_addr),
    .busy_any(busy_any)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        we_a;
    logic [4:0]  aa;
    logic [31:0] da;
    logic        we_b;
    logic [4:0]  ab;
    logic [31:0] db;
    logic        bs;
    logic [4:0]  ba;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [31:0] d1;
    logic [31:0] d2;
    logic        b1;
    logic        b2;
    logic        any;
  } vec_t;

  vec_t tbl [15];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic idle();
    wr_en_a = 0; wr_addr_a = 0; wr_data_a = 0;
    wr_en_b = 0; wr_addr_b = 0; wr_data_b = 0;
    busy_set = 0; busy_addr = 0;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      m_mem[i]  = 0;
      m_busy[i] = 0;
    end
  endtask

  // Architectural effect of one clock edge.
  task automatic model_edge();
    if (reset) begin
      if (wr_en_a && wr_addr_a != 0) m_mem[wr_addr_a] = wr_data_a;
      if (wr_en_b && wr_addr_b != 0) m_mem[wr_addr_b] = wr_data_b;
      if (wr_en_b) m_busy[wr_addr_b] = 0;
      if (busy_set && busy_addr != 0) m_busy[busy_addr] = 1;
    end
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  // What a reader must see this cycle.
  task automatic model_read(input logic [4:0] a,
                            output logic [31:0] d,
                            output logic b);
    d = m_mem[a];
    b = m_busy[a];
    if (a == 0) begin
      d = 0; b = 0;
    end else if (wr_en_b && wr_addr_b == a) begin
      d = wr_data_b; b = 0;
    end else if (wr_en_a && wr_addr_a == a) begin
      d = wr_data_a;
    end
  endtask

  function automatic logic model_any();
    logic r;
    r = 0;
    for (int i = 0; i < 32; i++) r |= m_busy[i];
    return r;
  endfunction

  task automatic chk_model(input string tag);
    logic [31:0] d;
    logic        b;
    model_read(rd_addr1, d, b);
    chk({tag, " d1"}, rd_data1, d);
    chk({tag, " b1"}, {31'd0, rd_busy1}, {31'd0, b});
    model_read(rd_addr2, d, b);
    chk({tag, " d2"}, rd_data2, d);
    chk({tag, " b2"}, {31'd0, rd_busy2}, {31'd0, b});
    chk({tag, " any"}, {31'd0, busy_any}, {31'd0, model_any()});
  endtask

  task automatic chk_all_zero(input string tag);
    for (int a = 0; a < 32; a++) begin
      rd_addr1 = 5'(a);
      rd_addr2 = 5'(31 - a);
      #0.1;
      chk({tag, " d1"}, rd_data1, 0);
      chk({tag, " d2"}, rd_data2, 0);
      chk({tag, " b1"}, {31'd0, rd_busy1}, 0);
    end
    chk({tag, " any"}, {31'd0, busy_any}, 0);
  endtask

  initial begin
    tbl[0]  = '{0,1,200, 0,0,0, 0,0, 1,0, 0,0,0,0,0};
    tbl[1]  = '{1,1,200, 0,0,0, 0,0, 1,0, 200,0,0,0,0};
    tbl[2]  = '{0,0,0, 0,0,0, 0,0, 1,1, 200,200,0,0,0};
    tbl[3]  = '{1,2,300, 1,3,3, 0,0, 2,3, 300,3,0,0,0};
    tbl[4]  = '{1,4,7, 1,4,9, 0,0, 4,2, 9,300,0,0,0};
    tbl[5]  = '{0,0,0, 0,0,0, 0,0, 4,3, 9,3,0,0,0};
    tbl[6]  = '{1,0,32'hDEADBEEF, 0,0,0, 1,0, 0,1,
                0,200,0,0,0};
    tbl[7]  = '{0,0,0, 0,0,0, 0,0, 0,2, 0,300,0,0,0};
    tbl[8]  = '{0,0,0, 0,0,0, 1,5, 5,0, 0,0,0,0,0};
    tbl[9]  = '{0,0,0, 0,0,0, 0,0, 5,5, 0,0,1,1,1};
    tbl[10] = '{0,0,0, 1,5,42, 0,0, 5,5, 42,42,0,0,1};
    tbl[11] = '{0,0,0, 0,0,0, 0,0, 5,4, 42,9,0,0,0};
    tbl[12] = '{0,0,0, 0,0,0, 1,6, 6,0, 0,0,0,0,0};
    tbl[13] = '{0,0,0, 1,6,11, 1,6, 6,5, 11,42,0,0,1};
    tbl[14] = '{0,0,0, 0,0,0, 0,0, 6,6, 11,11,1,1,1};

    // Reset held with random activity.
    reset = 0;
    idle();
    rd_addr1 = 0; rd_addr2 = 0;
    model_clear();
    for (int c = 0; c < 4; c++) begin
      #1;
      wr_en_a = 1; wr_addr_a = 5'($urandom);
      wr_data_a = $urandom;
      wr_en_b = 1; wr_addr_b = 5'($urandom);
      wr_data_b = $urandom;
      busy_set = 1; busy_addr = 5'($urandom);
      rd_addr1 = wr_addr_a; rd_addr2 = wr_addr_b;
      #1;
      chk("rst d1", rd_data1, 0);
      chk("rst d2", rd_data2, 0);
      chk("rst b1", {31'd0, rd_busy1}, 0);
      chk("rst any", {31'd0, busy_any}, 0);
      @(posedge clock);
    end
    @(negedge clock);
    idle();
    reset = 1;
    @(posedge clock);
    #1;
    chk_all_zero("post-rst");

    // Directed table.
    for (int i = 0; i < 15; i++) begin
      wr_en_a = tbl[i].we_a; wr_addr_a = tbl[i].aa;
      wr_data_a = tbl[i].da;
      wr_en_b = tbl[i].we_b; wr_addr_b = tbl[i].ab;
      wr_data_b = tbl[i].db;
      busy_set = tbl[i].bs; busy_addr = tbl[i].ba;
      rd_addr1 = tbl[i].r1; rd_addr2 = tbl[i].r2;
      #1;
      chk($sformatf("tbl%0d d1", i), rd_data1, tbl[i].d1);
      chk($sformatf("tbl%0d d2", i), rd_data2, tbl[i].d2);
      chk($sformatf("tbl%0d b1", i),
          {31'd0, rd_busy1}, {31'd0, tbl[i].b1});
      chk($sformatf("tbl%0d b2", i),
          {31'd0, rd_busy2}, {31'd0, tbl[i].b2});
      chk($sformatf("tbl%0d any", i),
          {31'd0, busy_any}, {31'd0, tbl[i].any});
      step();
    end
    idle();

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      wr_en_a = 1'($urandom);
      wr_addr_a = 5'($urandom_range(0, 7));
      wr_data_a = $urandom;
      wr_en_b = 1'($urandom);
      wr_addr_b = ($urandom_range(0, 3) == 0) ? wr_addr_a
                : 5'($urandom_range(0, 7));
      wr_data_b = $urandom;
      busy_set = 1'($urandom);
      busy_addr = ($urandom_range(0, 3) == 0) ? wr_addr_b
                : 5'($urandom_range(0, 7));
      rd_addr1 = ($urandom_range(0, 1) == 0) ? wr_addr_a
               : 5'($urandom_range(0, 31));
      rd_addr2 = ($urandom_range(0, 1) == 0) ? wr_addr_b
               : 5'($urandom_range(0, 7));
      #1;
      chk_model("rnd");
      step();
    end

    // Populate r1..r6 then reset between edges.
    for (int r = 1; r <= 6; r++) begin
      idle();
      wr_en_a = 1; wr_addr_a = 5'(r); wr_data_a = 32'(r * 1000 + 5);
      busy_set = 1; busy_addr = 5'(r);
      rd_addr1 = 5'(r); rd_addr2 = 5'(r);
      #1;
      chk_model("pop");
      step();
    end
    idle();
    rd_addr1 = 3; rd_addr2 = 4;
    #1;
    chk_model("pre-arst");
    #1;
    reset = 0;
    wr_en_a = 1; wr_addr_a = 1; wr_data_a = 32'h55;
    wr_en_b = 1; wr_addr_b = 2; wr_data_b = 32'h66;
    model_clear();
    for (int r = 1; r <= 6; r += 2) begin
      rd_addr1 = 5'(r); rd_addr2 = 5'(r + 1);
      #1;
      chk("arst d1", rd_data1, 0);
      chk("arst d2", rd_data2, 0);
      chk("arst b1", {31'd0, rd_busy1}, 0);
      chk("arst b2", {31'd0, rd_busy2}, 0);
      chk("arst any", {31'd0, busy_any}, 0);
    end
    @(posedge clock);
    @(negedge clock);
    idle();
    reset = 1;
    @(posedge clock);
    #1;
    chk_all_zero("post-arst");

    // First write right after release.
    wr_en_a = 1; wr_addr_a = 9; wr_data_a = 32'h1234;
    rd_addr1 = 9; rd_addr2 = 1;
    step();
    idle();
    #1;
    chk_model("after-rel");
    chk("after-rel r9", rd_data1, 32'h1234);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file for the single-cycle/pipelined datapath, successor to the 32x32 two-read/one-write file. Provides two combinational read ports and two write ports: port A for ALU writeback, port B for late data return such as loads. Per-register busy bits form a scoreboard so the decode stage can detect reads of registers with an outstanding write. Optional write-to-read bypass and a hardwired zero register are selected by parameter.

## Interface

- `DATA_W`, default 32, register width in bits.
- `ADDR_W`, default 5, address width; depth is 2**ADDR_W entries.
- `ZERO_REG`, default 1, when 1 entry 0 always reads 0, ignores writes and is never busy.
- `BYPASS`, default 1, when 1 a same-cycle write is forwarded to matching read ports.

- `clock`  in  1  rising-edge clock for all state.
- `reset`  in  1  asynchronous, active-low reset (asserted when 0).
- `rd_addr1`  in  ADDR_W  read port 1 address.
- `rd_addr2`  in  ADDR_W  read port 2 address.
- `rd_data1`  out  DATA_W  read port 1 data, combinational.
- `rd_data2`  out  DATA_W  read port 2 data, combinational.
- `rd_busy1`  out  1  busy bit of `rd_addr1`, after bypass/clear rules.
- `rd_busy2`  out  1  busy bit of `rd_addr2`.
- `wr_en_a`  in  1  write enable, port A.
- `wr_addr_a`  in  ADDR_W  write address, port A.
- `wr_data_a`  in  DATA_W  write data, port A.
- `wr_en_b`  in  1  write enable, port B; also clears the busy bit.
- `wr_addr_b`  in  ADDR_W  write address, port B.
- `wr_data_b`  in  DATA_W  write data, port B.
- `busy_set`  in  1  mark `busy_addr` as having an outstanding port-B write.
- `busy_addr`  in  ADDR_W  register to mark busy.
- `busy_any`  out  1  OR of all busy bits, registered state.

## Operation

- Storage: 2**ADDR_W x DATA_W registers plus 2**ADDR_W busy bits.
- Reset (`reset`=0): all registers and busy bits clear to 0 immediately, without a clock edge. Outputs reflect this combinationally: `rd_data*`=0, `rd_busy*`=0, `busy_any`=0. Writes and busy_set are ignored while reset is asserted.
- Write, rising edge: `wr_en_a` stores `wr_data_a` at `wr_addr_a`, and `wr_en_b` stores `wr_data_b` at `wr_addr_b`.
- Write collision (both enabled, same address): port B wins. The busy bit is still cleared by B.
- Busy update per edge, in this order:
  - Clear `busy[wr_addr_b]` if `wr_en_b`.
  - Then set `busy[busy_addr]` if `busy_set`.
  - Set on the same address as a clear leaves the bit at 1, because a new producer supersedes the old one.
  - `busy_set` on an already-busy entry leaves it at 1, with no counting.
- ZERO_REG=1:
  - Writes to address 0 are discarded.
  - `busy_set` to 0 is ignored.
  - Reads of address 0 return 0 and busy 0, regardless of bypass.
- Read, BYPASS=0: `rd_dataN` = stored value at `rd_addrN`, and `rd_busyN` = stored busy bit.
- Read, BYPASS=1:
  - Data: if `wr_en_b` and `wr_addr_b`==`rd_addrN`, return `wr_data_b`. Else if `wr_en_a` and `wr_addr_a`==`rd_addrN`, return `wr_data_a`. Else return the stored value. Priority matches the collision rule.
  - Busy: `rd_busyN` = stored busy AND NOT (`wr_en_b` and `wr_addr_b`==`rd_addrN`). Same-cycle `busy_set` is not forwarded.
- Both read ports are independent; identical addresses give identical outputs.

## Timing

- Read latency is 0 cycles, purely combinational from address, stored state and (BYPASS=1) write inputs.
- Write latency is 1 edge. The stored value is visible without bypass from the cycle after the edge.
- `busy_any` is registered state: it updates one edge after the set or clear.
- Reset mid-operation: an asynchronous assert clears state within the same cycle. Deassertion is sampled by the next rising edge; the first write can occur on the first edge with `reset`=1.
- No stalls or handshakes; every enabled write completes on its edge.

## Test plan

- Reset then read: hold `reset`=0 with random inputs, then release -> `rd_data1`=`rd_data2`=0 for addresses 0..31, `busy_any`=0.
- Write-enable gating: `wr_en_a`=0 with addr 1, data 200, one edge -> read 1 returns 0. Then `wr_en_a`=1 -> read 1 returns 200 (200 visible the same cycle with BYPASS=1).
- Dual write and collision: A writes 300 to r2 while B writes 3 to r3; the next cycle A writes 7 and B writes 9 both to r4 -> r2=300, r3=3, r4=9.
- Zero register: write 0xDEADBEEF to r0 and `busy_set` r0 -> `rd_data1`=0, `rd_busy1`=0, `busy_any`=0.
- Scoreboard:
  - `busy_set` r5 -> next cycle `rd_busy1`(r5)=1, `busy_any`=1.
  - B writes 42 to r5 -> `rd_busy1`=0 and `rd_data1`=42 in the same cycle (BYPASS=1).
  - Next cycle `busy_any`=0.
  - Simultaneous clear and set on r6 -> r6 stays busy.
- Async reset mid-run: after populating r1..r6, pull `reset` low between edges -> all outputs 0 before the next edge, and state stays 0 after release.
